// File: rtl/lfsr_checker.sv
// lfsr_checker: serial PRBS checker for the 15-bit XNOR LFSR stream
// (taps 14/13, shift-left, feedback into bit 0, each transmitted bit is
// the generator's new bit 0).
//
// The checker fills a 15-bit predictor from the received stream and then
// verifies LOCK_CNT consecutive predictions. Once locked it runs the
// predictor as a flywheel, so received errors never corrupt it, and it
// tracks error density over a WINDOW-bit window.
//
// Ports:
//   clk        clock, all logic on posedge
//   reset      synchronous, active-high, overrides every other input
//   bit_valid  qualifies bit_in this cycle
//   bit_in     received stream bit
//   clr_count  synchronous clear of err_count
//   locked     high while in LOCKED
//   err_pulse  one-cycle pulse per mismatched bit while locked
//   sync_lost  one-cycle pulse on LOCKED -> SEARCH
//   err_count  saturating count of locked mismatches
//
// Build option: define LFSR_CHK_ERRCNT_EN to include the err_count counter
// and clr_count handling. Without it err_count is tied to 0, clr_count is
// ignored and no counter flops exist.
module lfsr_checker #(
  parameter int LOCK_CNT  = 16,
  parameter int ERR_LIMIT = 4,
  parameter int WINDOW    = 64,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr_count,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_lost,
  output logic [CNT_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  localparam logic [MW-1:0] LOCK_TGT = MW'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_TGT  = WW'(WINDOW);
  localparam logic [EW-1:0] ERR_TGT  = EW'(ERR_LIMIT);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [14:0]     sr, sr_nx;
  logic [3:0]      fill_cnt, fill_nx;
  logic [MW-1:0]   match_cnt, match_nx;
  logic [WW-1:0]   win_cnt, win_nx;
  logic [EW-1:0]   win_err, win_err_nx;
  logic            locked_nx, err_pulse_nx, sync_lost_nx;

  logic            exp_bit;
  logic            hit;
  logic [14:0]     shifted;
  logic            fill_done;
  logic            lockup;
  logic            match_done;
  logic            limit_hit;
  logic            window_end;
  logic            bit_err;

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  assign exp_bit    = ~(sr[14] ^ sr[13]);
  assign hit        = (bit_in == exp_bit);
  assign shifted    = {sr[13:0], bit_in};
  // fill_cnt == 14 means the current bit is the 15th; 15 means the fill is
  // complete but the predictor was stuck in the all-ones lockup state.
  assign fill_done  = (fill_cnt >= 4'd14);
  // All ones is the XNOR lockup state; a real generator never emits it, so
  // a predictor seeded with it would "verify" a constant-1 stream.
  assign lockup     = (shifted == 15'h7FFF);
  assign match_done = ((match_cnt + MW'(1)) == LOCK_TGT);
  assign limit_hit  = ((win_err + EW'(1)) == ERR_TGT);
  assign window_end = ((win_cnt + WW'(1)) == WIN_TGT);
  assign bit_err    = bit_valid && (state == LOCKED) && !hit;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    if (bit_valid) begin
      case (state)
        SEARCH:  if (fill_done && !lockup) state_nx = VERIFY;
        VERIFY: begin
          if (!hit)            state_nx = SEARCH;
          else if (match_done) state_nx = LOCKED;
        end
        LOCKED:  if (!hit && limit_hit) state_nx = SEARCH;
        default: state_nx = SEARCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Predictor and counters, next values
  // ---------------------------------------------------------------------------
  always_comb begin
    sr_nx      = sr;
    fill_nx    = fill_cnt;
    match_nx   = match_cnt;
    win_nx     = win_cnt;
    win_err_nx = win_err;
    if (bit_valid) begin
      case (state)
        SEARCH: begin
          sr_nx    = shifted;
          fill_nx  = fill_done ? 4'd15 : fill_cnt + 4'd1;
          match_nx = '0;
        end
        VERIFY: begin
          sr_nx = shifted;
          if (hit) begin
            match_nx = match_cnt + MW'(1);
            if (match_done) begin
              win_nx     = '0;
              win_err_nx = '0;
            end
          end else begin
            // The mismatching bit is already shifted in and counts as the
            // first bit of the new fill.
            fill_nx  = 4'd1;
            match_nx = '0;
          end
        end
        LOCKED: begin
          // Flywheel: advance on the predicted bit, not the received one.
          sr_nx  = {sr[13:0], exp_bit};
          win_nx = win_cnt + WW'(1);
          if (!hit) win_err_nx = win_err + EW'(1);
          if (!hit && limit_hit) begin
            sr_nx      = '0;
            fill_nx    = '0;
            win_nx     = '0;
            win_err_nx = '0;
          end else if (window_end) begin
            // An error on the last window bit was counted above against the
            // old window before both counters restart.
            win_nx     = '0;
            win_err_nx = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
    end else begin
      sr        <= sr_nx;
      fill_cnt  <= fill_nx;
      match_cnt <= match_nx;
      win_cnt   <= win_nx;
      win_err   <= win_err_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (registered, latency 1 from the sampled bit)
  // ---------------------------------------------------------------------------
  always_comb begin
    locked_nx    = (state_nx == LOCKED);
    err_pulse_nx = bit_err;
    sync_lost_nx = bit_err && limit_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      locked    <= locked_nx;
      err_pulse <= err_pulse_nx;
      sync_lost <= sync_lost_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter (optional)
  // ---------------------------------------------------------------------------
`ifdef LFSR_CHK_ERRCNT_EN
  logic [CNT_W-1:0] cnt;

  // A clear that coincides with an error leaves that error counted.
  always_ff @(posedge clk) begin
    if (reset)                  cnt <= '0;
    else if (clr_count)         cnt <= {{(CNT_W-1){1'b0}}, bit_err};
    else if (bit_err && ~&cnt)  cnt <= cnt + CNT_W'(1);
  end

  assign err_count = cnt;
`else
  logic unused_clr;
  assign unused_clr = clr_count;
  assign err_count  = '0;
`endif

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_sync_implies_err: assert property (@(posedge clk) disable iff (reset)
    sync_lost |-> (err_pulse && !locked));

  a_err_only_locked: assert property (@(posedge clk) disable iff (reset)
    err_pulse |-> $past(locked));

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clr_count = 1'b0;
  logic        locked, err_pulse, sync_lost;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  lfsr_checker #(
    .LOCK_CNT(16), .ERR_LIMIT(4), .WINDOW(64), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
    .clr_count(clr_count), .locked(locked), .err_pulse(err_pulse),
    .sync_lost(sync_lost), .err_count(err_count)
  );

  typedef struct {
    logic        rst, valid, din, clr;
    logic        locked, pulse, sync;
    logic [15:0] cnt;
    int          rep;
  } vec_t;

  typedef struct {
    logic        locked, pulse, sync;
    logic [15:0] cnt;
    int          sc, step;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_fail = 0;
  int          sc_no = 0, step_no = 0;
  logic [14:0] g;          // transmitter generator state
  logic        e_locked;
  logic [15:0] e_cnt;

  function automatic logic [15:0] cnt_next(logic [15:0] cur, logic err, logic clr);
`ifdef LFSR_CHK_ERRCNT_EN
    if (clr) return err ? 16'd1 : 16'd0;
    if (err && cur != 16'hFFFF) return cur + 16'd1;
    return cur;
`else
    return 16'd0;
`endif
  endfunction

  // Scoreboard checker: one expectation per driven cycle, compared after the edge.
  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      if ({locked, err_pulse, sync_lost, err_count} !== {e.locked, e.pulse, e.sync, e.cnt}) begin
        n_fail++;
        $display("FAIL outputs sc%0d step%0d: locked/err_pulse/sync_lost/err_count got %b/%b/%b/%0d want %b/%b/%b/%0d",
                 e.sc, e.step, locked, err_pulse, sync_lost, err_count, e.locked, e.pulse, e.sync, e.cnt);
      end
    end
  end

  task automatic send(input logic r, input logic v, input logic d, input logic c,
                      input logic el, input logic ep, input logic es, input logic [15:0] ec);
    exp_t e;
    @(negedge clk);
    reset = r; bit_valid = v; bit_in = d; clr_count = c;
    step_no++;
    e.locked = el; e.pulse = ep; e.sync = es; e.cnt = ec;
    e.sc = sc_no; e.step = step_no;
    sb.push_back(e);
  endtask

  // Next generator bit, optionally flipped on the wire; el_after is the
  // expected locked state after this bit.
  task automatic tx(input logic flip, input logic clr, input logic el_after);
    logic b, err;
    b = ~(g[14] ^ g[13]);
    g = {g[13:0], b};
    err = flip & e_locked;
    e_cnt = cnt_next(e_cnt, err, clr);
    send(1'b0, 1'b1, b ^ flip, clr, el_after, err, err & ~el_after, e_cnt);
    e_locked = el_after;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      send(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, e_locked, 1'b0, 1'b0, e_cnt);
  endtask

  task automatic do_reset();
    send(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         1'b0, 1'b0, 1'b0, 16'h0);
    e_locked = 1'b0; e_cnt = 16'h0; g = 15'h0;
  endtask

  // From reset: 15 fill bits + 16 verify bits, locked after the 31st.
  task automatic lock_up();
    do_reset();
    for (int i = 1; i <= 31; i++) tx(1'b0, 1'b0, i == 31);
  endtask

  initial begin
    vec_t tbl[4];
    int   nf;
    // {rst, valid, din, clr, locked, pulse, sync, cnt, rep}
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 2};   // reset state
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 5};   // invalid bits ignored
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1};   // clear alone
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 40};  // all-ones lockup rejected

    // sc1: table, then a real stream after the lockup pattern still locks at bit 31
    sc_no = 1;
    foreach (tbl[k])
      for (int r = 0; r < tbl[k].rep; r++)
        send(tbl[k].rst, tbl[k].valid, tbl[k].din, tbl[k].clr,
             tbl[k].locked, tbl[k].pulse, tbl[k].sync, tbl[k].cnt);
    e_locked = 1'b0; e_cnt = 16'h0; g = 15'h0;
    for (int i = 1; i <= 31; i++) tx(1'b0, 1'b0, i == 31);

    // sc2: error during VERIFY drops back to SEARCH without err_pulse
    sc_no = 2;
    do_reset();
    for (int i = 0; i < 20; i++) tx(1'b0, 1'b0, 1'b0);
    tx(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tx(1'b0, 1'b0, 1'b0);

    // sc3: clean generator, 1000 bits with random gaps
    sc_no = 3;
    lock_up();
    for (int i = 32; i <= 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      tx(1'b0, 1'b0, 1'b1);
    end

    // sc4: single error, flywheel keeps predicting, idle cycles hold predictor
    sc_no = 4;
    tx(1'b1, 1'b0, 1'b1);
    idle(10);
    for (int i = 0; i < 30; i++) tx(1'b0, 1'b0, 1'b1);

    // sc5: 4 errors in one window lose lock; clean stream relocks after 31 bits
    sc_no = 5;
    lock_up();
    nf = 0;
    for (int i = 1; i <= 30; i++) begin
      logic f;
      f = (i == 6 || i == 10 || i == 20 || i == 30);
      if (f) nf++;
      tx(f, 1'b0, !(f && nf == 4));
    end
    for (int i = 1; i <= 31; i++) tx(1'b0, 1'b0, i == 31);
    for (int i = 0; i < 5; i++) tx(1'b0, 1'b0, 1'b1);

    // sc6: 3 errors per window for 10 windows, clears, then 4 errors ending on
    // the last window bit
    sc_no = 6;
    lock_up();
    for (int w = 0; w < 10; w++)
      for (int p = 1; p <= 64; p++)
        tx(p == 5 || p == 20 || p == 40, 1'b0, 1'b1);
    tx(1'b0, 1'b1, 1'b1);
    tx(1'b1, 1'b1, 1'b1);
    for (int p = 3; p <= 64; p++) tx(1'b0, 1'b0, 1'b1);
    for (int p = 1; p <= 64; p++) tx(p >= 61, 1'b0, p != 64);

    // sc7: reset while locked with 7 errors counted, then idle
    sc_no = 7;
    lock_up();
    nf = 0;
    for (int i = 1; i <= 140; i++) begin
      logic f;
      f = ((i % 64) == 10 || (i % 64) == 20 || (i % 64) == 30) && nf < 7;
      if (f) nf++;
      tx(f, 1'b0, 1'b1);
    end
    do_reset();
    idle(10);

    repeat (3) @(posedge clk);
    #3;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker for the 15-bit XNOR-feedback LFSR stream (taps 14 and 13, shift-left, feedback into bit 0) used as the design's pseudo-random source. It consumes one received bit per qualified cycle, self-synchronises its own 15-bit predictor from the incoming stream, then compares each following bit against the predicted bit. It reports lock status, per-bit error pulses, a saturating error count and loss-of-sync events. It sits at the receiving end of any path that carries the LFSR feedback bit sequence, for built-in self-test of that path.

## Interface
- LOCK_CNT, 16: consecutive correct predictions in VERIFY required to assert lock (1..255).
- ERR_LIMIT, 4: errors within one window that force loss of lock (1..WINDOW).
- WINDOW, 64: valid-bit length of the error-density window in LOCKED (2..65535).
- CNT_W, 16: width of err_count.
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high; overrides every other input.
- bit_valid  in  1  qualifies bit_in this cycle.
- bit_in  in  1  received stream bit.
- clr_count  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatched bit in LOCKED.
- sync_lost  out  1  one-cycle pulse on the LOCKED->SEARCH transition.
- err_count  out  CNT_W  saturating count of LOCKED mismatches.

## Operation
- Predictor sr[14:0]; expected bit exp = ~(sr[14] ^ sr[13]). Stream convention: each transmitted bit is the generator's feedback bit (its new bit 0).
- States: SEARCH, VERIFY, LOCKED. Reset: state SEARCH, sr = 0, all counters 0, all outputs 0.
- Cycles with bit_valid = 0 change nothing except clearing pulses.
- SEARCH: sr <= {sr[13:0], bit_in}; fill counter increments. On 15th bit: if the resulting sr is 15'h7FFF (XNOR lockup state, never produced by the generator), stay in SEARCH with fill counter held at 15 and keep shifting, re-testing each new bit; otherwise go to VERIFY with match counter 0.
- VERIFY: sr <= {sr[13:0], bit_in}. bit_in == exp: match counter +1; on reaching LOCK_CNT go to LOCKED, clear window and window-error counters. Mismatch: go to SEARCH, fill counter = 1 (this bit is the first fill bit). No err_pulse in VERIFY.
- LOCKED: sr <= {sr[13:0], exp} (flywheel; received errors never corrupt the predictor). Window counter +1 per valid bit. Mismatch: err_pulse, err_count +1 (saturate at all-ones), window-error counter +1. If window-error counter reaches ERR_LIMIT: go to SEARCH, sync_lost pulse, sr and fill counter cleared. When window counter reaches WINDOW without hitting the limit, both window counters restart at 0 (the error on the WINDOW-th bit still counts toward the old window first).
- clr_count and a simultaneous error: err_count = 1. clr_count alone: err_count = 0. Lock loss does not clear err_count.

## Timing
- All outputs registered. err_pulse, sync_lost and locked change in the cycle after the posedge that sampled the relevant bit (latency 1).
- Minimum lock time from reset: 15 + LOCK_CNT valid bits; locked high one cycle after the last of them.
- Throughput one bit per clock; bit_valid may toggle arbitrarily.
- Reset mid-operation: next cycle state SEARCH, all outputs 0, err_count 0.

## Configuration
- LFSR_CHK_ERRCNT_EN defined: err_count counter and clr_count logic present as above.
- Not defined: err_count tied to 0, clr_count ignored, no counter flops; locked, err_pulse, sync_lost unchanged.

## Test plan
- Generator from reset (first bits: fourteen 1s then 0, sr = 15'h7FFE), LOCK_CNT=16 -> locked rises one cycle after bit 31; err_pulse never fires over 1000 bits; err_count = 0.
- Locked stream, flip one bit -> single err_pulse one cycle later, err_count = 1, locked stays 1, following bits match (flywheel).
- Locked, 4 flipped bits within 64 bits (ERR_LIMIT=4, WINDOW=64) -> sync_lost pulse after 4th, locked = 0, err_count = 4; clean stream relocks after 31 more valid bits.
- Locked, 3 errors per 64-bit window repeated 10 windows -> never loses lock, err_count = 30; assert clr_count -> 0.
- Fifteen 1s input -> stays SEARCH (lockup rejected), locked = 0; flip bit during VERIFY -> back to SEARCH, no err_pulse.
- Assert reset while locked with err_count = 7 -> next cycle locked = 0, err_count = 0, pulses 0; bit_valid held low -> no state change.
